// File: rtl/mod_mul_serial.sv
// mod_mul_serial: bit-serial modular multiplier, out = (opA * opB) mod opM.
// Scans opB MSB-first, one bit per clock, using interleaved double-and-add
// with a conditional subtract after each step. A result takes WIDTH cycles.
module mod_mul_serial #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [WIDTH-1:0] opM,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r, state_next_s;
  logic [WIDTH-1:0] a_r, a_next_s;
  logic [WIDTH-1:0] b_r, b_next_s;
  logic [WIDTH-1:0] m_r, m_next_s;
  logic [WIDTH-1:0] acc_r, acc_next_s;
  logic [IW-1:0]    idx_r, idx_next_s;
  logic [WIDTH-1:0] out_data_next_s;
  logic             out_valid_next_s;
  logic [WIDTH-1:0] dbl_s;
  logic [WIDTH-1:0] step_s;

  // Modular add of two residues below m. The sum is formed one bit wider so
  // it cannot wrap (it is below 2m), and one subtract brings it back in range.
  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, m}) begin
      s = s - {1'b0, m};
    end else begin
      s = s;
    end
    return s[WIDTH-1:0];
  endfunction

  // One iteration of the interleaved multiply: R <- 2R (+ A if the bit is set).
  always_comb begin
    dbl_s = add_mod(acc_r, acc_r, m_r);
    if (b_r[idx_r]) begin
      step_s = add_mod(dbl_s, a_r, m_r);
    end else begin
      step_s = dbl_s;
    end
  end

  // Next-state and next-register values; everything holds unless changed.
  always_comb begin
    state_next_s     = state_r;
    a_next_s         = a_r;
    b_next_s         = b_r;
    m_next_s         = m_r;
    acc_next_s       = acc_r;
    idx_next_s       = idx_r;
    out_data_next_s  = out_data;
    out_valid_next_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          a_next_s     = opA;
          b_next_s     = opB;
          m_next_s     = opM;
          acc_next_s   = '0;
          idx_next_s   = IW'(WIDTH - 1);
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        acc_next_s = step_s;
        if (idx_r == '0) begin
          out_data_next_s  = step_s;
          out_valid_next_s = 1'b1;
          state_next_s     = IDLE;
        end else begin
          idx_next_s   = idx_r - IW'(1);
          state_next_s = RUN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; busy is registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      m_r       <= '0;
      acc_r     <= '0;
      idx_r     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state_r   <= state_next_s;
      a_r       <= a_next_s;
      b_r       <= b_next_s;
      m_r       <= m_next_s;
      acc_r     <= acc_next_s;
      idx_r     <= idx_next_s;
      busy      <= (state_next_s == RUN);
      out_valid <= out_valid_next_s;
      out_data  <= out_data_next_s;
    end
  end

endmodule
